// File: rtl/sigmoid_pkg.sv
// Shared types and the operand-to-LUT-index rule for the sigmoid activation path.
package sigmoid_pkg;

   localparam int unsigned SIG_IN_WIDTH   = 16;
   localparam int unsigned SIG_FRAC_SHIFT = 4;
   localparam int unsigned SIG_MEM_WIDTH  = 5;
   localparam int unsigned SIG_DATA_WIDTH = 8;
   localparam int unsigned SIG_DEPTH      = 2 ** SIG_MEM_WIDTH;
   localparam int          SIG_HALF       = 2 ** (SIG_MEM_WIDTH - 1);

   typedef logic [SIG_MEM_WIDTH-1:0]         sig_idx_t;
   typedef logic signed [SIG_DATA_WIDTH-1:0] sig_act_t;

   // Drop fraction bits, saturate to the table range, then offset so entry 0 is the most-negative input.
   function automatic sig_idx_t sig_index(input logic [SIG_IN_WIDTH-1:0] operand,
                                          input int unsigned             shift);
      logic signed [SIG_IN_WIDTH-1:0] s;
      int                             sv;
      s  = $signed(operand) >>> shift;
      sv = int'(s);
      if (sv < -SIG_HALF) return '0;
      if (sv > SIG_HALF - 1) return '1;
      return sig_idx_t'(sv + SIG_HALF);
   endfunction

endpackage

// File: rtl/sigmoid_func.sv
// Sigmoid lookup table: synchronous 1-cycle read, no reset. Entry k holds round(127*sigmoid((k-16)/4)).
module sigmoid_func
   import sigmoid_pkg::*;
(
   input  logic                      clk,
   input  logic [SIG_MEM_WIDTH-1:0]  addr,
   output logic [SIG_DATA_WIDTH-1:0] q
);

   localparam sig_act_t ROM [SIG_DEPTH] = '{
      8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd8,   8'd10,  8'd12,
      8'd15,  8'd19,  8'd23,  8'd28,  8'd34,  8'd41,  8'd48,  8'd56,
      8'd64,  8'd71,  8'd79,  8'd86,  8'd93,  8'd99,  8'd104, 8'd108,
      8'd112, 8'd115, 8'd117, 8'd119, 8'd121, 8'd122, 8'd123, 8'd124
   };

   always_ff @(posedge clk) begin
      q <= ROM[addr];
   end

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin sharing of one sigmoid LUT between NUM_REQ accumulators, two-stage lockstep pipeline.
module sigmoid_lut_arbiter
   import sigmoid_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned IN_WIDTH   = SIG_IN_WIDTH,
   parameter int unsigned FRAC_SHIFT = SIG_FRAC_SHIFT,
   parameter int unsigned MEM_WIDTH  = SIG_MEM_WIDTH,
   parameter int unsigned DATA_WIDTH = SIG_DATA_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic                        idle
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic                  run;
   logic                  v1, v2;
   logic [ID_W-1:0]       rr_ptr, id1, id2;
   logic [ID_W-1:0]       gnt_id, rr_next;
   logic                  gnt_any, adv, hs;
   logic [MEM_WIDTH-1:0]  addr_q, addr2_q, lut_addr, new_addr;
   logic [DATA_WIDTH-1:0] lut_q;

   assign adv = !v2 || rsp_ready;
   assign hs  = run && adv && gnt_any;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned p;
      gnt_any = 1'b0;
      gnt_id  = '0;
      p       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         p = 32'(rr_ptr) + k;
         if (p >= NUM_REQ) p = p - NUM_REQ;
         if (!gnt_any && req_valid[ID_W'(p)]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(p);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[gnt_id] = 1'b1;
   end

   assign rr_next  = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
   assign new_addr = MEM_WIDTH'(sig_index(SIG_IN_WIDTH'(req_data[32'(gnt_id)*IN_WIDTH +: IN_WIDTH]),
                                          FRAC_SHIFT));

   // Under stall the LUT re-reads the stage-2 address so its registered word does not move.
   assign lut_addr = adv ? addr_q : addr2_q;

   // run gates req_ready so nothing is accepted while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         rr_ptr  <= '0;
         id1     <= '0;
         id2     <= '0;
         addr_q  <= '0;
         addr2_q <= '0;
      end else begin
         run <= 1'b1;
         if (adv) begin
            v1      <= hs;
            v2      <= v1;
            id2     <= id1;
            addr2_q <= addr_q;
            if (hs) begin
               addr_q <= new_addr;
               id1    <= gnt_id;
               rr_ptr <= rr_next;
            end
         end
      end
   end

   sigmoid_func u_lut (
      .clk  (clk),
      .addr (lut_addr),
      .q    (lut_q)
   );

   assign rsp_valid = v2;
   assign rsp_data  = v2 ? lut_q : '0;
   assign rsp_id    = id2;
   assign idle      = !v1 && !v2;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed and randomized checks of the shared sigmoid LUT arbiter against hand-computed activations.
module tb_sigmoid_lut_arbiter;

   localparam int NUM_REQ = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        idle;

   sigmoid_lut_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .idle      (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // round(127*sigmoid(x/4)) for x = -16..15
   logic [7:0] lut_tab [32] = '{
      8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd8,   8'd10,  8'd12,
      8'd15,  8'd19,  8'd23,  8'd28,  8'd34,  8'd41,  8'd48,  8'd56,
      8'd64,  8'd71,  8'd79,  8'd86,  8'd93,  8'd99,  8'd104, 8'd108,
      8'd112, 8'd115, 8'd117, 8'd119, 8'd121, 8'd122, 8'd123, 8'd124
   };
   // requester i sends i*64 -> s=4i -> idx 16+4i
   logic [7:0] fair_act [4] = '{8'd64, 8'd93, 8'd112, 8'd121};

   typedef struct {
      int         id;
      logic [7:0] act;
   } sb_t;

   sb_t        sb [$];
   int         checks = 0;
   int         errors = 0;
   int         ops    = 0;
   bit         mon_en = 1'b0;
   logic [3:0] fired  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_idx(input logic [15:0] d);
      int s;
      s = int'($signed(d)) >>> 4;
      if (s < -16) return 0;
      if (s > 15) return 31;
      return s + 16;
   endfunction

   function automatic logic [15:0] rand_op();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 1023)) - 16'd512;
   endfunction

   // Handshakes are observed on the falling edge, half a cycle before the edge that commits them.
   always @(negedge clk) begin
      fired = req_valid & req_ready;
      if (mon_en) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i])
               sb.push_back('{id: i, act: lut_tab[ref_idx(req_data[i*16 +: 16])]});
         if (rsp_valid && rsp_ready) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < sb.size(); k++) begin
               if (sb[k].id == int'(rsp_id)) begin
                  check("sb_data", 32'(rsp_data), 32'(sb[k].act));
                  sb.delete(k);
                  found = 1'b1;
                  break;
               end
            end
            check("sb_hit", 32'(found), 32'd1);
            ops++;
         end
      end
   end

   task automatic single_op(input int i, input logic [15:0] d, input logic [7:0] exp_act);
      req_valid    = '0;
      req_valid[i] = 1'b1;
      req_data[i*16 +: 16] = d;
      #1;
      check("op_rdy", 32'(req_ready), 32'(1 << i));
      tick();
      check("op_lat1", 32'(rsp_valid), 32'd0);
      req_valid = '0;
      tick();
      check("op_valid", 32'(rsp_valid), 32'd1);
      check("op_data", 32'(rsp_data), 32'(exp_act));
      check("op_id", 32'(rsp_id), 32'(i));
      tick();
      check("op_idle", 32'(idle), 32'd1);
   endtask

   initial begin
      int n;
      int cyc;
      logic [7:0] held_d;
      logic [1:0] held_id;

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data", 32'(rsp_data), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      req_valid = 4'b1111;
      #1;
      check("rst_rdy", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst_n = 1'b1;
      tick();
      tick();

      // latency and saturation
      single_op(2, 16'h0030, 8'd86);
      single_op(0, 16'h8000, 8'd2);
      single_op(0, 16'h7FFF, 8'd124);
      single_op(0, 16'hFFF0, 8'd56);

      // reset with the pipeline busy
      for (int i = 0; i < NUM_REQ; i++) req_data[i*16 +: 16] = 16'(i * 64);
      req_valid = 4'b1111;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_rdy", 32'(req_ready), 32'd0);
      check("mid_rst_idle", 32'(idle), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // fairness: all four valid, strict rotation from requester 0
      n = 0;
      for (int t = 0; t < 16; t++) begin
         if (t == 12) req_valid = '0;
         if (t < 12) check("fair_rdy", 32'(req_ready), 32'(1 << (t % 4)));
         if (t < 2) check("rst_no_rsp", 32'(rsp_valid), 32'd0);
         if (t >= 2 && t < 14) check("fair_valid", 32'(rsp_valid), 32'd1);
         if (rsp_valid) begin
            check("fair_id", 32'(rsp_id), 32'(n % 4));
            check("fair_data", 32'(rsp_data), 32'(fair_act[n % 4]));
            n++;
         end
         tick();
      end
      check("fair_cnt", 32'(n), 32'd12);

      // backpressure with a full pipeline
      sb.delete();
      mon_en    = 1'b1;
      req_valid = 4'b1111;
      tick();
      tick();
      tick();
      rsp_ready = 1'b0;
      #1;
      held_d  = rsp_data;
      held_id = rsp_id;
      check("bp_full", 32'(rsp_valid), 32'd1);
      check("bp_rdy", 32'(req_ready), 32'd0);
      for (int t = 0; t < 5; t++) begin
         tick();
         check("bp_data", 32'(rsp_data), 32'(held_d));
         check("bp_id", 32'(rsp_id), 32'(held_id));
         check("bp_rdy", 32'(req_ready), 32'd0);
         check("bp_busy", 32'(idle), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(req_ready != 4'b0000), 32'd1);
      for (int t = 0; t < 4; t++) tick();
      req_valid = '0;
      for (int t = 0; t < 4; t++) tick();
      check("bp_sb_empty", 32'(sb.size()), 32'd0);
      check("bp_idle", 32'(idle), 32'd1);

      // random valid/ready traffic
      ops = 0;
      cyc = 0;
      while (ops < 10000 && cyc < 40000) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || fired[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_data[i*16 +: 16] = rand_op();
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
      end
      check("rand_ops", 32'(ops >= 10000), 32'd1);
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int t = 0; t < 4; t++) tick();
      check("rand_sb_empty", 32'(sb.size()), 32'd0);
      check("rand_idle", 32'(idle), 32'd1);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
